fft_in_pair_buffer: RTL and testbench
=====================================

# fft_in_pair_buffer

Input pairing stage feeding the 8-lane radix-2 butterfly (BF2I) of the first FFT stage. It accepts a stream of DEPTH-lane complex vectors (R/Q), stores the first half of each frame, and emits each stored vector alongside its partner from the second half (index k paired with k+HALF). The butterfly then computes sum and difference on each pair. Its registered `dout_valid` drives the butterfly's `en` directly.

## Interface
- WIDTH, 15, signed sample width per lane (R and Q); equals butterfly input width
- DEPTH, 8, lanes per vector
- HALF, 4, vectors per half-frame; frame = 2*HALF vectors; power of two, ≥1
- clk  input  1  rising-edge clock
- rstn  input  1  reset; one clock; reset is synchronous and active-low
- din_valid  input  1  din vector present this cycle
- din_sync  input  1  qualified by din_valid; marks vector as frame index 0
- din_R  input  WIDTH×DEPTH  signed real lanes
- din_Q  input  WIDTH×DEPTH  signed imag lanes
- dout_valid  output  1  pair valid; drives butterfly en
- dout_last  output  1  high with final pair of a frame
- dout_R_1, dout_Q_1  output  WIDTH×DEPTH  stored first-half vector k
- dout_R_2, dout_Q_2  output  WIDTH×DEPTH  second-half vector k+HALF
- sync_err  output  1  one-cycle pulse: din_sync arrived with cnt≠0

## Operation
- Frame counter cnt, range 0..2*HALF-1. Advances only on din_valid; wraps 2*HALF-1 → 0.
- States derive from cnt MSB:
  - FILL (cnt<HALF): on din_valid, write din_R/din_Q into buf[cnt].
  - PAIR (cnt≥HALF): on din_valid, register buf[cnt-HALF] → *_1 and din → *_2. Assert dout_valid.
- dout_last = dout_valid when the paired vector was cnt=2*HALF-1.
- din_sync with din_valid:
  - Forces the vector to index 0: written to buf[0], next cnt=1.
  - Any partial frame is discarded; no pairs emitted for it.
  - If cnt≠0 at that moment, pulse sync_err the next cycle.
  - din_sync with cnt=0 is normal; no error.
- din_valid low: cnt and buf hold; dout_valid=0, dout_last=0. Data outputs hold their last values.
- No arithmetic, no width change; samples pass bit-exact. Lane i of the input maps to lane i of the output.
- Buffer: HALF×DEPTH×2 words of WIDTH bits in flops; no reset of buffer contents required.
- Frames are back-to-back capable: the FILL of frame n+1 may immediately follow the last PAIR of frame n.

## Timing
- Reset (rstn low at a clk edge): cnt=0, dout_valid=0, dout_last=0, sync_err=0, all dout_* data=0. Takes effect at that edge.
- Reset mid-frame aborts the frame. The first valid vector after reset is index 0 regardless of din_sync.
- Latency: 1 clk. The pair for vector cnt=HALF+k is visible the cycle after it is accepted.
- Throughput: one vector/cycle; HALF output pairs per 2*HALF accepted vectors.
- dout_valid is a pure register output; no combinational path from din to any output.
- din_valid and rstn low in the same cycle: reset wins and the vector is dropped.
- No backpressure: the downstream stage always accepts.

## Test plan
- Continuous frame, HALF=4, lane i of vector v = 16v+i (R), −(16v+i) (Q), valid every cycle, din_sync on v=0.
  - Required: dout_valid high on cycles 5–8 after the first vector.
  - Pair k: R_1 lane i = 16k+i, R_2 lane i = 16(k+4)+i. dout_last only on k=3.
- Bubbles: same frame with din_valid low on alternating cycles.
  - Required: identical pair values; dout_valid only the cycle after each second-half vector.
  - Data outputs hold between pairs.
- Extremes: lanes = 16383 and −16384 (WIDTH=15) in both halves.
  - Required: passed bit-exact, no sign corruption.
- Resync: din_sync at cnt=2 mid-FILL, then a full frame.
  - Required: sync_err one-cycle pulse. The pairs reference only post-sync vectors; no pair from the aborted frame.
- Reset mid-PAIR: assert rstn low after the second pair.
  - Required: next cycle all outputs 0 and dout_valid 0. The next 8 vectors form a clean frame without din_sync.
- Back-to-back: three frames with no gaps.
  - Required: 12 pairs, dout_last every 4th pair, no stale buffer data crossing frames.

Source files
------------

// File: rtl/fft_in_pair_buffer.sv
// -----------------------------------------------------------------------------
// fft_in_pair_buffer
//
// Input pairing stage in front of the first radix-2 butterfly of the FFT.
// A frame is 2*HALF vectors, and each vector carries DEPTH complex lanes.
// The first half of a frame (indices 0..HALF-1) is stored in a flop buffer.
// Each vector of the second half (index HALF+k) is then emitted together with
// its stored partner k, one clock after it is accepted.
//
// Ports
//   clk         rising-edge clock
//   rstn        synchronous, active-low reset
//   din_valid   input vector present this cycle
//   din_sync    qualified by din_valid; forces this vector to frame index 0
//   din_R/Q     DEPTH signed lanes of WIDTH bits (lane i at [i*WIDTH +: WIDTH])
//   dout_valid  registered pair strobe; drives the butterfly enable
//   dout_last   high together with the final pair of a frame
//   dout_R_1/Q_1  stored first-half vector k
//   dout_R_2/Q_2  second-half vector k+HALF
//   sync_err    one-cycle pulse when din_sync arrived at a nonzero frame index
// -----------------------------------------------------------------------------
module fft_in_pair_buffer #(
   parameter int WIDTH = 15,
   parameter int DEPTH = 8,
   parameter int HALF  = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   din_valid,
   input  logic                   din_sync,
   input  logic [WIDTH*DEPTH-1:0] din_R,
   input  logic [WIDTH*DEPTH-1:0] din_Q,
   output logic                   dout_valid,
   output logic                   dout_last,
   output logic [WIDTH*DEPTH-1:0] dout_R_1,
   output logic [WIDTH*DEPTH-1:0] dout_Q_1,
   output logic [WIDTH*DEPTH-1:0] dout_R_2,
   output logic [WIDTH*DEPTH-1:0] dout_Q_2,
   output logic                   sync_err
);

   localparam int VW    = WIDTH * DEPTH;
   localparam int FRAME = 2 * HALF;
   localparam int CW    = $clog2(FRAME);
   localparam int IW    = (HALF > 1) ? $clog2(HALF) : 1;

   localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // FILL stores the first half of a frame, PAIR emits the pairs.
   // The phase is decoded from the frame counter, not held in its own register.
   typedef enum logic {FILL, PAIR} phase_e;

   // Frame-half buffer, one word per stored vector
   logic [VW-1:0] mem_r_q [HALF];
   logic [VW-1:0] mem_q_q [HALF];
   logic          mem_we;
   logic [IW-1:0] mem_waddr;
   logic [IW-1:0] rd_idx;

   logic [CW-1:0] cnt_q,        cnt_d;
   logic          dout_valid_q, dout_valid_d;
   logic          dout_last_q,  dout_last_d;
   logic          sync_err_q,   sync_err_d;
   logic [VW-1:0] dout_r_1_q,   dout_r_1_d;
   logic [VW-1:0] dout_q_1_q,   dout_q_1_d;
   logic [VW-1:0] dout_r_2_q,   dout_r_2_d;
   logic [VW-1:0] dout_q_2_q,   dout_q_2_d;

   phase_e phase;

   // -------------------------------------------------------------------------
   // Phase decode and partner read index
   // -------------------------------------------------------------------------
   always_comb begin
      phase  = (cnt_q >= CNT_HALF) ? PAIR : FILL;
      // Vector HALF+k reads its partner from slot k
      rd_idx = IW'(cnt_q - CNT_HALF);
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first, so no path through this block
      // leaves a value unassigned and no latch is inferred.
      cnt_d        = cnt_q;
      dout_valid_d = 1'b0;
      dout_last_d  = 1'b0;
      sync_err_d   = 1'b0;
      dout_r_1_d   = dout_r_1_q;
      dout_q_1_d   = dout_q_1_q;
      dout_r_2_d   = dout_r_2_q;
      dout_q_2_d   = dout_q_2_q;
      mem_we       = 1'b0;
      mem_waddr    = '0;

      // A vector presented while reset is low is dropped, buffer included
      if (din_valid && rstn) begin
         if (din_sync) begin
            // Re-align: this vector becomes index 0, and any partial frame is
            // abandoned without emitting pairs
            mem_we     = 1'b1;
            mem_waddr  = '0;
            cnt_d      = CNT_ONE;
            sync_err_d = (cnt_q != '0);
         end else if (phase == FILL) begin
            mem_we    = 1'b1;
            mem_waddr = IW'(cnt_q);
            cnt_d     = cnt_q + CNT_ONE;
         end else begin
            dout_valid_d = 1'b1;
            dout_last_d  = (cnt_q == CNT_LAST);
            dout_r_1_d   = mem_r_q[rd_idx];
            dout_q_1_d   = mem_q_q[rd_idx];
            dout_r_2_d   = din_R;
            dout_q_2_d   = din_Q;
            cnt_d        = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Control and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the values from before the edge and the result does not
      // depend on the order in which processes run.
      if (!rstn) begin
         cnt_q        <= '0;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
         sync_err_q   <= 1'b0;
         dout_r_1_q   <= '0;
         dout_q_1_q   <= '0;
         dout_r_2_q   <= '0;
         dout_q_2_q   <= '0;
      end else begin
         cnt_q        <= cnt_d;
         dout_valid_q <= dout_valid_d;
         dout_last_q  <= dout_last_d;
         sync_err_q   <= sync_err_d;
         dout_r_1_q   <= dout_r_1_d;
         dout_q_1_q   <= dout_q_1_d;
         dout_r_2_q   <= dout_r_2_d;
         dout_q_2_q   <= dout_q_2_d;
      end
   end

   // -------------------------------------------------------------------------
   // Half-frame buffer
   // -------------------------------------------------------------------------
   // NOTE: the buffer has no reset. A slot is always written during FILL
   // before any PAIR cycle reads it, so a reset would only add clear logic.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_r_q[mem_waddr] <= din_R;
         mem_q_q[mem_waddr] <= din_Q;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs come straight from registers
   // -------------------------------------------------------------------------
   always_comb begin
      dout_valid = dout_valid_q;
      dout_last  = dout_last_q;
      sync_err   = sync_err_q;
      dout_R_1   = dout_r_1_q;
      dout_Q_1   = dout_q_1_q;
      dout_R_2   = dout_r_2_q;
      dout_Q_2   = dout_q_2_q;
   end

endmodule

// File: tb/tb_fft_in_pair_buffer.sv
// -----------------------------------------------------------------------------
// tb_fft_in_pair_buffer
//
// Directed bench for fft_in_pair_buffer. The stimulus side keeps a model of
// the frame index and of the stored first-half vectors. Each time it sends a
// second-half vector, it pushes the expected pair into a queue, tagged with
// the clock edge at which the pair must appear. It also queues the edges at
// which sync_err must pulse.
//
// The monitor runs 1 time unit after each rising edge. It checks the reset
// values, dout_valid timing, the pair contents, dout_last, the hold of the
// data outputs between pairs, and sync_err.
// -----------------------------------------------------------------------------
module tb_fft_in_pair_buffer;

   localparam int WIDTH = 15;
   localparam int DEPTH = 8;
   localparam int HALF  = 4;
   localparam int VW    = WIDTH * DEPTH;

   typedef struct {
      logic [VW-1:0] r1;
      logic [VW-1:0] q1;
      logic [VW-1:0] r2;
      logic [VW-1:0] q2;
      logic          last;
      int            edge_n;
   } exp_t;

   logic          clk;
   logic          rstn;
   logic          din_valid;
   logic          din_sync;
   logic [VW-1:0] din_R;
   logic [VW-1:0] din_Q;
   logic          dout_valid;
   logic          dout_last;
   logic [VW-1:0] dout_R_1;
   logic [VW-1:0] dout_Q_1;
   logic [VW-1:0] dout_R_2;
   logic [VW-1:0] dout_Q_2;
   logic          sync_err;

   int   checks = 0;
   int   errors = 0;
   int   edge_n = 0;
   exp_t exp_q[$];
   int   se_q[$];

   // Stimulus-side model: frame index and the stored first half of the frame
   int            mcnt = 0;
   logic [VW-1:0] mb_r [HALF];
   logic [VW-1:0] mb_q [HALF];

   fft_in_pair_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HALF(HALF)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .din_valid  (din_valid),
      .din_sync   (din_sync),
      .din_R      (din_R),
      .din_Q      (din_Q),
      .dout_valid (dout_valid),
      .dout_last  (dout_last),
      .dout_R_1   (dout_R_1),
      .dout_Q_1   (dout_Q_1),
      .dout_R_2   (dout_R_2),
      .dout_Q_2   (dout_Q_2),
      .sync_err   (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s edge %0d: got %h expected %h", name, edge_n, act, req);
      end
   endtask

   // Lane i = 16v+i, negated when neg is set
   function automatic logic [VW-1:0] ramp(input int v, input bit neg);
      logic [VW-1:0] r;
      int s;
      r = '0;
      for (int i = 0; i < DEPTH; i++) begin
         s = 16 * v + i;
         if (neg) s = -s;
         r[i*WIDTH +: WIDTH] = WIDTH'(s);
      end
      return r;
   endfunction

   // Even lanes take a, odd lanes take b
   function automatic logic [VW-1:0] alt(input int a, input int b);
      logic [VW-1:0] r;
      r = '0;
      for (int i = 0; i < DEPTH; i++)
         r[i*WIDTH +: WIDTH] = WIDTH'((i % 2 == 0) ? a : b);
      return r;
   endfunction

   // Drive one vector and update the model. Anything driven at this negedge
   // is accepted at edge edge_n+1.
   task automatic send_vec(input bit sync, input logic [VW-1:0] r, input logic [VW-1:0] q);
      exp_t e;
      @(negedge clk);
      rstn      = 1'b1;
      din_valid = 1'b1;
      din_sync  = sync;
      din_R     = r;
      din_Q     = q;
      if (sync) begin
         if (mcnt != 0) se_q.push_back(edge_n + 1);
         mb_r[0] = r;
         mb_q[0] = q;
         mcnt    = 1;
      end else if (mcnt < HALF) begin
         mb_r[mcnt] = r;
         mb_q[mcnt] = q;
         mcnt++;
      end else begin
         e.r1     = mb_r[mcnt-HALF];
         e.q1     = mb_q[mcnt-HALF];
         e.r2     = r;
         e.q2     = q;
         e.last   = (mcnt == 2*HALF-1);
         e.edge_n = edge_n + 1;
         exp_q.push_back(e);
         mcnt = (mcnt + 1) % (2*HALF);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rstn      = 1'b1;
         din_valid = 1'b0;
         din_sync  = 1'b0;
         din_R     = {VW{1'b1}};
         din_Q     = {VW{1'b1}};
      end
   endtask

   // One reset cycle with a valid vector presented: reset must win
   task automatic do_reset();
      @(negedge clk);
      rstn      = 1'b0;
      din_valid = 1'b1;
      din_sync  = 1'b0;
      din_R     = ramp(900, 0);
      din_Q     = ramp(900, 1);
      mcnt      = 0;
   endtask

   task automatic send_frame(input int base, input bit sync_first, input bit gap);
      for (int v = 0; v < 2*HALF; v++) begin
         send_vec(sync_first && (v == 0), ramp(base + v, 0), ramp(base + v, 1));
         if (gap) idle(1);
      end
   endtask

   // Monitor / scoreboard
   always @(posedge clk) begin
      logic          rst_now;
      logic          exp_valid;
      logic          exp_se;
      exp_t          e;
      logic [VW-1:0] h_r1, h_q1, h_r2, h_q2;
      rst_now = !rstn;
      edge_n++;
      #1;
      if (rst_now) begin
         check("rst_valid", VW'(dout_valid), VW'(0));
         check("rst_last",  VW'(dout_last),  VW'(0));
         check("rst_serr",  VW'(sync_err),   VW'(0));
         check("rst_R_1", dout_R_1, '0);
         check("rst_Q_1", dout_Q_1, '0);
         check("rst_R_2", dout_R_2, '0);
         check("rst_Q_2", dout_Q_2, '0);
         h_r1 = '0; h_q1 = '0; h_r2 = '0; h_q2 = '0;
      end else begin
         exp_valid = (exp_q.size() > 0) && (exp_q[0].edge_n == edge_n);
         check("dout_valid", VW'(dout_valid), VW'(exp_valid));
         if (exp_valid) begin
            e = exp_q.pop_front();
            check("pair_R_1", dout_R_1, e.r1);
            check("pair_Q_1", dout_Q_1, e.q1);
            check("pair_R_2", dout_R_2, e.r2);
            check("pair_Q_2", dout_Q_2, e.q2);
            check("pair_last", VW'(dout_last), VW'(e.last));
            h_r1 = e.r1; h_q1 = e.q1; h_r2 = e.r2; h_q2 = e.q2;
         end else begin
            check("idle_last", VW'(dout_last), VW'(0));
            check("hold_R_1", dout_R_1, h_r1);
            check("hold_Q_1", dout_Q_1, h_q1);
            check("hold_R_2", dout_R_2, h_r2);
            check("hold_Q_2", dout_Q_2, h_q2);
         end
         exp_se = (se_q.size() > 0) && (se_q[0] == edge_n);
         if (exp_se) void'(se_q.pop_front());
         check("sync_err", VW'(sync_err), VW'(exp_se));
      end
   end

   initial begin
      rstn      = 1'b0;
      din_valid = 1'b0;
      din_sync  = 1'b0;
      din_R     = '0;
      din_Q     = '0;
      do_reset();
      do_reset();
      idle(2);

      // Continuous frame with din_sync on v=0
      send_frame(0, 1'b1, 1'b0);
      idle(3);

      // Same frame with a bubble after every vector
      send_frame(0, 1'b1, 1'b1);
      idle(2);

      // Extreme values in both halves
      for (int v = 0; v < HALF; v++)
         send_vec(v == 0, alt(16383, -16384), alt(-16384, 16383));
      for (int v = 0; v < HALF; v++)
         send_vec(1'b0, alt(-16384, 16383), alt(16383, -16384));
      idle(2);

      // Resync at cnt=2 during FILL
      send_vec(1'b0, ramp(50, 0), ramp(50, 1));
      send_vec(1'b0, ramp(51, 0), ramp(51, 1));
      send_frame(60, 1'b1, 1'b0);
      idle(2);

      // Reset after the second pair, then a clean frame without din_sync
      for (int v = 0; v < HALF + 2; v++)
         send_vec(1'b0, ramp(10 + v, 0), ramp(10 + v, 1));
      do_reset();
      send_frame(20, 1'b0, 1'b0);
      idle(2);

      // Three back-to-back frames
      send_frame(30, 1'b1, 1'b0);
      send_frame(38, 1'b0, 1'b0);
      send_frame(46, 1'b0, 1'b0);
      idle(4);

      check("pairs_drained", VW'(exp_q.size()), VW'(0));
      check("sync_drained",  VW'(se_q.size()),  VW'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
